// File: rtl/bit_deserializer.sv
//------------------------------------------------------------------------------
// bit_deserializer: collects N serial bits into one word, then hands it off.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bit_deserializer #(
    parameter int N         = 32,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     bit_in,
    input  logic                     bit_valid,
    output logic                     bit_ready,
    output logic [N-1:0]             out_word,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(N):0]       count
);

    localparam int W = $clog2(N);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [W-1:0]   index;
    logic [W-1:0]   pos;
    logic           accept;
    logic           handoff;

    assign bit_ready = (state == COLLECT);
    assign out_valid = (state == FULL);
    assign accept    = bit_ready && bit_valid;
    assign handoff   = out_valid && out_ready;
    assign pos       = MSB_FIRST ? (W'(N - 1) - index) : index;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // clear overrides both handshakes
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = COLLECT;
        end else begin
            case (state)
                COLLECT: if (accept && (index == W'(N - 1))) state_next = FULL;
                FULL:    if (out_ready)                      state_next = COLLECT;
                default:                                     state_next = COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index    <= '0;
            count    <= '0;
            out_word <= '0;
        end else if (clear) begin
            index    <= '0;
            count    <= '0;
            out_word <= '0;
        end else if (accept) begin
            out_word[pos] <= bit_in;
            index         <= index + W'(1);
            count         <= count + (W + 1)'(1);
        end else if (handoff) begin
            count    <= '0;
            out_word <= '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bit_deserializer.sv
//------------------------------------------------------------------------------
// tb_bit_deserializer: scoreboard bench driving an LSB-first and an MSB-first
// N=8 instance from the same stimulus. Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_bit_deserializer;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       out_ready = 1'b0;

    logic       lsb_ready, msb_ready, lsb_valid, msb_valid;
    logic [7:0] lsb_word, msb_word;
    logic [3:0] lsb_count, msb_count;

    int tests = 0;
    int failed = 0;

    bit_deserializer #(.N(N), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .clear(clear), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(lsb_ready), .out_word(lsb_word), .out_valid(lsb_valid),
        .out_ready(out_ready), .count(lsb_count)
    );

    bit_deserializer #(.N(N), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .clear(clear), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(msb_ready), .out_word(msb_word), .out_valid(msb_valid),
        .out_ready(out_ready), .count(msb_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: fills m_word in arrival order, pushes finished words.
    logic       m_full = 1'b0;
    int         m_cnt = 0;
    logic [7:0] m_word = '0;
    logic [7:0] q_lsb[$];
    logic [7:0] q_msb[$];

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst || clear) begin
            m_full = 1'b0; m_cnt = 0; m_word = '0;
            q_lsb.delete(); q_msb.delete();
        end else if (!m_full) begin
            if (bit_valid) begin
                m_word[m_cnt] = bit_in;
                m_cnt++;
                if (m_cnt == N) begin
                    m_full = 1'b1;
                    q_lsb.push_back(m_word);
                    q_msb.push_back(rev8(m_word));
                end
            end
        end else if (out_ready) begin
            m_full = 1'b0; m_cnt = 0; m_word = '0;
        end
    end

    bit         mon_en = 1'b0;
    logic       prev_valid = 1'b0;
    logic [7:0] cur_l = '0, cur_m = '0;
    int         words_seen = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            check("lsb_ready", lsb_ready, !m_full);
            check("msb_ready", msb_ready, !m_full);
            check("lsb_valid", lsb_valid, m_full);
            check("msb_valid", msb_valid, m_full);
            check("lsb_count", lsb_count, m_cnt);
            check("msb_count", msb_count, m_cnt);
            if (lsb_valid && !prev_valid) begin
                words_seen++;
                check("sb_pending", q_lsb.size(), 1);
                if (q_lsb.size() > 0) begin
                    cur_l = q_lsb.pop_front();
                    cur_m = q_msb.pop_front();
                end
            end
            if (lsb_valid) begin
                check("lsb_word", lsb_word, cur_l);
                check("msb_word", msb_word, cur_m);
            end else begin
                check("lsb_partial", lsb_word, m_word);
                check("msb_partial", msb_word, rev8(m_word));
            end
            prev_valid = lsb_valid;
        end
    end

    task automatic drive(input logic v, input logic b, input logic r, input logic c);
        bit_valid = v; bit_in = b; out_ready = r; clear = c;
        @(posedge clk); #1;
    endtask

    task automatic feed(input logic [7:0] bits, input int n);
        for (int i = 0; i < n; i++) drive(1'b1, bits[i], 1'b0, 1'b0);
        bit_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] pat;
        int         w0;
        pat = 8'b0100_1101;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        check("rst_ready", lsb_ready, 1'b1);
        check("rst_word", lsb_word, 8'h00);

        // fixed pattern into both orderings, then held off for 5 cycles
        feed(pat, 8);
        check("lsb_4D", lsb_word, 8'h4D);
        check("msb_B2", msb_word, 8'hB2);
        check("full_count", lsb_count, 4'd8);
        check("full_ready", lsb_ready, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'(i), 1'b0, 1'b0);
        check("hold_msb", msb_word, 8'hB2);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check("handoff_valid", msb_valid, 1'b0);
        check("handoff_word", msb_word, 8'h00);
        check("handoff_count", msb_count, 4'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // gapped valid, all ones
        for (int i = 0; i < 16; i++) drive(1'(~i[0]), 1'b1, 1'b0, 1'b0);
        check("gapped_FF", lsb_word, 8'hFF);
        drive(1'b0, 1'b0, 1'b1, 1'b0);

        // clear mid-word drops the concurrent bit
        feed(8'b0000_0111, 3);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        check("clear_count", lsb_count, 4'd0);
        check("clear_word", lsb_word, 8'h00);
        feed(8'h96, 8);
        check("fresh_word", lsb_word, 8'h96);
        drive(1'b0, 1'b0, 1'b1, 1'b0);

        // back-to-back with out_ready held high
        w0 = words_seen;
        for (int i = 0; i < 18; i++) drive(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("b2b_words", words_seen - w0, 2);

        // clear wins over handoff while FULL
        feed(8'h5A, 8);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        check("clear_full_valid", lsb_valid, 1'b0);
        check("clear_full_count", lsb_count, 4'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // asynchronous reset mid-word and while FULL
        feed(8'h07, 3);
        #2 rst = 1'b1;
        #1 check("arst_mid_count", lsb_count, 4'd0);
        check("arst_mid_word", lsb_word, 8'h00);
        @(posedge clk); #1 rst = 1'b0;
        feed(8'hC3, 8);
        #2 rst = 1'b1;
        #1 check("arst_full_valid", msb_valid, 1'b0);
        check("arst_full_word", msb_word, 8'h00);
        check("arst_full_count", msb_count, 4'd0);
        @(posedge clk); #1 rst = 1'b0;
        check("arst_ready", lsb_ready, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        check("sb_drain", q_lsb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
